// File: rtl/conv2_kernel_fetch.sv
// Kernel-weight fetch sequencer for conv2: reads one kernel from a dual-port ROM
// (two words per cycle) and streams weight pairs through a 2-entry valid/ready FIFO.
module conv2_kernel_fetch #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KWORDS = 25,
  parameter int unsigned KIDX_W = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [KIDX_W-1:0]   i_kernel_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [ADDR_W-1:0]   o_rom_addr_a,
  output logic [ADDR_W-1:0]   o_rom_addr_b,
  input  logic [DATA_W-1:0]   i_rom_q_a,
  input  logic [DATA_W-1:0]   i_rom_q_b,
  output logic [2*DATA_W-1:0] o_w_data,
  output logic [1:0]          o_w_mask,
  output logic                o_w_valid,
  input  logic                i_w_ready,
  output logic                o_w_last
);

  localparam int unsigned NPAIRS = (KWORDS + 1) / 2;
  localparam int unsigned CNT_W = $clog2(NPAIRS + 1);
  localparam bit ODD = (KWORDS % 2) == 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(NPAIRS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

  state_t              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr_a, r_addr_b, r_addr_end;
  logic [CNT_W-1:0]    r_issued;
  logic                r_inf, r_inf_last, r_err;
  logic [1:0]          r_occ;
  logic [2*DATA_W-1:0] r_d0, r_d1;
  logic [1:0]          r_m0, r_m1;
  logic                r_l0, r_l1;

  logic [31:0]         w_kend;
  logic                w_idx_ok, w_accept, w_pop, w_push, w_issue, w_issue_last, w_zero_b;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W:0]     w_b_cand;
  logic [1:0]          w_occ_left, w_pmask;
  logic [DATA_W-1:0]   w_q_b;
  logic [2*DATA_W-1:0] w_pdata;

  always_comb begin
    w_kend     = (32'(i_kernel_idx) + 32'd1) * KWORDS;
    w_idx_ok   = w_kend <= (32'd1 << ADDR_W);
    w_base     = ADDR_W'(32'(i_kernel_idx) * KWORDS);
    w_accept   = (r_state == StIdle) && i_start && w_idx_ok;
    w_pop      = (r_occ != 2'd0) && i_w_ready;
    w_push     = r_inf;
    // Occupancy counted after this edge's pop so a full-rate stream keeps issuing.
    w_occ_left = r_occ - {1'b0, w_pop};
    w_issue    = (r_state == StFetch) && ((w_occ_left + {1'b0, r_inf}) < 2'd2);
    w_issue_last = w_issue && (r_issued == LAST_PAIR);
    w_b_cand   = {1'b0, r_addr_a} + (ADDR_W + 1)'(3);
    w_zero_b   = ODD && r_inf_last;
    w_q_b      = w_zero_b ? {DATA_W{1'b0}} : i_rom_q_b;
    w_pdata    = {w_q_b, i_rom_q_a};
    w_pmask    = w_zero_b ? 2'b01 : 2'b11;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_d = StFetch;
      StFetch: if (w_issue_last) w_state_d = StDrain;
      StDrain: if (w_pop && r_l0) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_addr_end <= '0;
      r_issued   <= '0;
      r_inf      <= 1'b0;
      r_inf_last <= 1'b0;
      r_err      <= 1'b0;
      r_occ      <= 2'd0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_m0       <= 2'b00;
      r_m1       <= 2'b00;
      r_l0       <= 1'b0;
      r_l1       <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_err      <= (r_state == StIdle) && i_start && !w_idx_ok;
      r_inf      <= w_issue;
      r_inf_last <= w_issue_last;
      if (w_accept) begin
        r_addr_a   <= w_base;
        r_addr_b   <= w_base + ADDR_W'(1);
        r_addr_end <= w_base + ADDR_W'(KWORDS - 1);
        r_issued   <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + CNT_W'(1);
        // Addresses hold on the final pair; lane b clamps to the kernel's last word.
        if (!w_issue_last) begin
          r_addr_a <= r_addr_a + ADDR_W'(2);
          r_addr_b <= (w_b_cand > {1'b0, r_addr_end}) ? r_addr_end : w_b_cand[ADDR_W-1:0];
        end
      end
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_d0 <= w_pdata;
            r_m0 <= w_pmask;
            r_l0 <= r_inf_last;
          end else begin
            r_d1 <= w_pdata;
            r_m1 <= w_pmask;
            r_l1 <= r_inf_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_m0  <= r_m1;
          r_l0  <= r_l1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_d0 <= w_pdata;
            r_m0 <= w_pmask;
            r_l0 <= r_inf_last;
          end else begin
            r_d0 <= r_d1;
            r_m0 <= r_m1;
            r_l0 <= r_l1;
            r_d1 <= w_pdata;
            r_m1 <= w_pmask;
            r_l1 <= r_inf_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy       = (r_state == StFetch) || (r_state == StDrain);
    o_done       = (r_state == StDone);
    o_err        = r_err;
    o_rom_addr_a = r_addr_a;
    o_rom_addr_b = r_addr_b;
    o_w_valid    = (r_occ != 2'd0);
    o_w_data     = r_d0;
    o_w_mask     = o_w_valid ? r_m0 : 2'b00;
    o_w_last     = o_w_valid && r_l0;
  end

endmodule

// File: tb/tb_conv2_kernel_fetch.sv
// Randomized scoreboard bench for conv2_kernel_fetch: expected weight pairs are
// derived from a ROM image and popped by an independent output monitor.
module tb_conv2_kernel_fetch;

  localparam int KW = 25;
  localparam int NP = 13;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mask;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  kidx = 4'd0;
  logic        busy, done, err, valid, last;
  logic        ready = 1'b1;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] q_a, q_b;
  logic [31:0] data;
  logic [1:0]  mask;

  logic [15:0] rom [256];
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic        ready_rnd = 1'b0;
  int          stall_left = 0;

  conv2_kernel_fetch dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_kernel_idx (kidx),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_rom_addr_a (addr_a),
    .o_rom_addr_b (addr_b),
    .i_rom_q_a    (q_a),
    .i_rom_q_b    (q_b),
    .o_w_data     (data),
    .o_w_mask     (mask),
    .o_w_valid    (valid),
    .i_w_ready    (ready),
    .o_w_last     (last)
  );

  always #5 clk = ~clk;

  // Registered-output ROM, one cycle of read latency.
  always @(posedge clk) begin
    q_a <= rom[addr_a];
    q_b <= rom[addr_b];
  end

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  // Consumer ready: held high, or random with occasional 5-cycle stalls.
  always @(posedge clk) begin
    int r;
    #2;
    if (stall_left > 0) begin
      ready = 1'b0;
      stall_left--;
    end else if (ready_rnd) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        ready = 1'b0;
        stall_left = 4;
      end else begin
        ready = r[0] | r[1];
      end
    end else begin
      ready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop on handshake and stability under stall.
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(valid), 64'd1);
        chk("stall_data_hold", 64'({data, mask, last}), 64'(prev_out));
      end
      prev_stall = valid && !ready;
      prev_out = {data, mask, last};
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got data %0h, expected no transfer", data);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_data", 64'(data), 64'(e.data));
          chk("xfer_mask", 64'(mask), 64'(e.mask));
          chk("xfer_last", 64'(last), 64'(e.last));
        end
        n_xfer++;
      end
    end
  end

  always @(negedge clk) begin
    if (busy && (addr_q.size() == 0 || addr_q[$] != {addr_a, addr_b}))
      addr_q.push_back({addr_a, addr_b});
  end

  task automatic push_kernel(input int idx);
    exp_t e;
    int   base;
    base = idx * KW;
    for (int k = 0; k < NP; k++) begin
      e.data[15:0] = rom[base + 2 * k];
      if (2 * k + 1 < KW) begin
        e.data[31:16] = rom[base + 2 * k + 1];
        e.mask = 2'b11;
      end else begin
        e.data[31:16] = 16'h0;
        e.mask = 2'b01;
      end
      e.last = (k == NP - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clk);
    start = 1'b1;
    kidx = idx[3:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, nv, idx;
    logic        busy_ok;
    logic [15:0] saved;
    logic [7:0]  eb;

    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, done, err, valid, last}), 64'd0);
    chk("reset_data", 64'({data, mask}), 64'd0);
    chk("reset_addr", 64'({addr_a, addr_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Kernel 0, ready held high: latency, throughput, addresses, done
    addr_q.delete();
    n_xfer = 0;
    push_kernel(0);
    pulse_start(0);
    chk("k0_busy_at_start", 64'(busy), 64'd1);
    chk("k0_first_addr", 64'({addr_a, addr_b}), 64'h0001);
    lat = 0;
    while (!valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("k0_first_valid_latency", 64'(lat), 64'd2);
    nv = 0;
    busy_ok = 1'b1;
    while (valid && nv < 40) begin
      busy_ok &= busy;
      nv++;
      @(posedge clk);
      #1;
    end
    chk("k0_valid_run", 64'(nv), 64'(NP));
    chk("k0_busy_during", 64'(busy_ok), 64'd1);
    chk("k0_done_after_last", 64'(done), 64'd1);
    chk("k0_busy_at_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("k0_done_one_cycle", 64'(done), 64'd0);
    chk("k0_addr_count", 64'(addr_q.size()), 64'(NP));
    for (int k = 0; k < NP && k < addr_q.size(); k++) begin
      eb = (2 * k + 1 < KW) ? 8'(2 * k + 1) : 8'(KW - 1);
      chk("k0_addr_seq", 64'(addr_q[k]), 64'({8'(2 * k), eb}));
    end

    // Kernel 9: highest valid index
    n_xfer = 0;
    push_kernel(9);
    pulse_start(9);
    wait_done("k9_done", 60);
    chk("k9_last_addr", 64'({addr_a, addr_b}), 64'({8'd249, 8'd249}));
    chk("k9_xfers", 64'(n_xfer), 64'(NP));

    // Out-of-range indices
    for (int t = 0; t < 2; t++) begin
      idx = (t == 0) ? 10 : 15;
      saved = {addr_a, addr_b};
      pulse_start(idx);
      chk("bad_idx_err", 64'(err), 64'd1);
      chk("bad_idx_busy", 64'(busy), 64'd0);
      busy_ok = 1'b1;
      @(posedge clk);
      #1;
      chk("bad_idx_err_pulse", 64'(err), 64'd0);
      repeat (4) begin
        busy_ok &= !busy && !valid;
        @(posedge clk);
        #1;
      end
      chk("bad_idx_quiet", 64'(busy_ok), 64'd1);
      chk("bad_idx_addr", 64'({addr_a, addr_b}), 64'(saved));
    end

    // Kernel 3 under random backpressure
    n_xfer = 0;
    push_kernel(3);
    ready_rnd = 1'b1;
    pulse_start(3);
    repeat (4) @(posedge clk);
    stall_left = 5;
    wait_done("k3_done", 800);
    ready_rnd = 1'b0;
    chk("k3_xfers", 64'(n_xfer), 64'(NP));
    chk("k3_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (8) @(posedge clk);

    // Kernel 4 with ignored starts during FETCH and during DRAIN
    n_xfer = 0;
    push_kernel(4);
    pulse_start(4);
    repeat (2) @(posedge clk);
    pulse_start(7);
    repeat (10) @(posedge clk);
    pulse_start(8);
    wait_done("k4_done", 60);
    chk("k4_xfers", 64'(n_xfer), 64'(NP));
    repeat (3) @(posedge clk);
    #1;
    chk("k4_no_restart", 64'({busy, valid}), 64'd0);
    chk("k4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during the 6th transfer, then kernel 1
    n_xfer = 0;
    push_kernel(2);
    pulse_start(2);
    nv = 0;
    while (!(n_xfer == 5 && valid) && nv < 40) begin
      @(posedge clk);
      #1;
      nv++;
    end
    chk("k2_reached_6th", 64'(n_xfer), 64'd5);
    rst = 1'b1;
    #1;
    chk("midreset_ctrl", 64'({busy, done, err, valid, last}), 64'd0);
    chk("midreset_data", 64'({data, mask, addr_a, addr_b}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_xfer = 0;
    push_kernel(1);
    pulse_start(1);
    wait_done("k1_done", 60);
    chk("k1_xfers", 64'(n_xfer), 64'(NP));
    chk("k1_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
